// File: rtl/sata_oob_controller_pkg.sv
// Shared definitions for the SATA OOB link-initialisation controller.
// Holds the primitive dwords exchanged during OOB, the state encoding
// (also the debug code on lax_state) and a small primitive-match helper.
package sata_oob_controller_pkg;

  // 8b/10b primitives as seen on the 32-bit parallel interface (byte0 is the K char)
  localparam logic [31:0] ALIGN_PRIM    = 32'h7B4A_4ABC;
  localparam logic [31:0] DIALTONE_PRIM = 32'h4A4A_4A4A;  // D10.2 repeated
  localparam logic [31:0] SYNC_PRIM     = 32'hB5B5_957C;

  // Width of the OOB/ALIGN wait timer; comfortably covers 66000 cycles
  localparam int unsigned TIMER_W = 32;

  // State codes double as the lax_state debug value
  typedef enum logic [3:0] {
    ST_IDLE             = 4'd0,
    ST_SEND_RESET       = 4'd1,
    ST_WAIT_FOR_INIT    = 4'd2,
    ST_WAIT_FOR_NO_INIT = 4'd3,
    ST_SEND_WAKE        = 4'd4,
    ST_WAIT_FOR_WAKE    = 4'd5,
    ST_WAIT_FOR_NO_WAKE = 4'd6,
    ST_WAIT_FOR_IDLE    = 4'd7,
    ST_WAIT_FOR_ALIGN   = 4'd8,
    ST_SEND_ALIGN       = 4'd9,
    ST_READY            = 4'd10
  } oob_state_e;

  // True when a received dword is the ALIGN primitive with its K flag set
  function automatic logic is_align(input logic [31:0] din, input logic isk0);
    return isk0 && (din == ALIGN_PRIM);
  endfunction

endpackage

// File: rtl/sata_oob_timer.sv
// Free-running wait timer for the OOB sequencer.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - restart counting from zero on the next edge
//   limit     - number of cycles after which tc is raised
//   tc        - high while the count equals limit-1 (last cycle of the window)
module sata_oob_timer
  import sata_oob_controller_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: restart on clear, otherwise advance
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {W{1'b0}};
    end else begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == (limit - {{(W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/sata_oob_controller.sv
// Host-side SATA OOB link-initialisation controller.
// Walks COMRESET -> COMINIT -> COMWAKE -> dial-tone -> ALIGN exchange until
// the device sends enough consecutive non-ALIGN primitives, then raises linkup.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   platform_ready              - transceiver/PLL ready; low forces IDLE
//   linkup                      - initialisation complete
//   tx_dout, tx_isk             - transmit dword and byte0 K flag while link is down
//   tx_comm_reset, tx_comm_wake - OOB burst requests to the transceiver
//   tx_set_elec_idle            - hold transmitter in electrical idle
//   tx_oob_complete             - requested OOB burst finished
//   rx_din, rx_isk              - received dword and per-byte K flags
//   comm_init_detect            - COMINIT seen
//   comm_wake_detect            - COMWAKE seen
//   rx_byte_is_aligned          - receiver comma alignment achieved
//   rx_is_elec_idle             - receiver line idle
//   lax_state                   - current state code for debug
module sata_oob_controller
  import sata_oob_controller_pkg::*;
#(
  parameter int unsigned OOB_TIMEOUT     = 66000,
  parameter int unsigned ALIGN_TIMEOUT   = 66000,
  parameter int unsigned NON_ALIGN_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        platform_ready,
  output logic        linkup,
  output logic [31:0] tx_dout,
  output logic        tx_isk,
  output logic        tx_comm_reset,
  output logic        tx_comm_wake,
  output logic        tx_set_elec_idle,
  input  logic        tx_oob_complete,
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_isk,
  input  logic        comm_init_detect,
  input  logic        comm_wake_detect,
  input  logic        rx_byte_is_aligned,
  input  logic        rx_is_elec_idle,
  output logic [3:0]  lax_state
);

  localparam int unsigned CNT_W = $clog2(NON_ALIGN_COUNT + 1);
  // Count value at which one more non-ALIGN primitive completes initialisation
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NON_ALIGN_COUNT - 1);

  oob_state_e       state_q;
  oob_state_e       state_d;
  logic [CNT_W-1:0] nonalign_q;
  logic [CNT_W-1:0] nonalign_d;

  logic        linkup_q, linkup_d;
  logic [31:0] tx_dout_q, tx_dout_d;
  logic        tx_isk_q, tx_isk_d;
  logic        tx_comm_reset_q, tx_comm_reset_d;
  logic        tx_comm_wake_q, tx_comm_wake_d;
  logic        tx_elec_idle_q, tx_elec_idle_d;

  logic        timer_tc_s;
  logic [TIMER_W-1:0] timer_limit_s;
  logic        rx_align_s;
  logic        rx_non_align_s;
  logic        unused_rx_isk_s;

  // Only byte0 carries a K character in the primitives we care about
  assign unused_rx_isk_s = &{1'b0, rx_isk[3:1]};

  assign rx_align_s     = is_align(rx_din, rx_isk[0]);
  assign rx_non_align_s = rx_isk[0] && !rx_align_s;

  // Both timed states share one timer; its window depends on which is active
  assign timer_limit_s = (state_q == ST_WAIT_FOR_ALIGN) ? TIMER_W'(ALIGN_TIMEOUT)
                                                        : TIMER_W'(OOB_TIMEOUT);

  sata_oob_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_d != state_q),
    .limit (timer_limit_s),
    .tc    (timer_tc_s)
  );

  // State, counter and registered Moore outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      nonalign_q      <= {CNT_W{1'b0}};
      linkup_q        <= 1'b0;
      tx_dout_q       <= 32'h0000_0000;
      tx_isk_q        <= 1'b0;
      tx_comm_reset_q <= 1'b0;
      tx_comm_wake_q  <= 1'b0;
      tx_elec_idle_q  <= 1'b1;
    end else begin
      state_q         <= state_d;
      nonalign_q      <= nonalign_d;
      linkup_q        <= linkup_d;
      tx_dout_q       <= tx_dout_d;
      tx_isk_q        <= tx_isk_d;
      tx_comm_reset_q <= tx_comm_reset_d;
      tx_comm_wake_q  <= tx_comm_wake_d;
      tx_elec_idle_q  <= tx_elec_idle_d;
    end
  end

  // Consecutive non-ALIGN counter; only meaningful while sending ALIGN
  always_comb begin
    nonalign_d = nonalign_q;
    if (state_q != ST_SEND_ALIGN) begin
      nonalign_d = {CNT_W{1'b0}};
    end else if (rx_non_align_s) begin
      nonalign_d = nonalign_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (rx_align_s) begin
      nonalign_d = {CNT_W{1'b0}};
    end else begin
      nonalign_d = nonalign_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!platform_ready) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEND_RESET;
        end
        ST_SEND_RESET: begin
          if (tx_oob_complete) state_d = ST_WAIT_FOR_INIT;
          else                 state_d = ST_SEND_RESET;
        end
        ST_WAIT_FOR_INIT: begin
          if (comm_init_detect) state_d = ST_WAIT_FOR_NO_INIT;
          else if (timer_tc_s)  state_d = ST_SEND_RESET;
          else                  state_d = ST_WAIT_FOR_INIT;
        end
        ST_WAIT_FOR_NO_INIT: begin
          if (!comm_init_detect) state_d = ST_SEND_WAKE;
          else                   state_d = ST_WAIT_FOR_NO_INIT;
        end
        ST_SEND_WAKE: begin
          if (tx_oob_complete) state_d = ST_WAIT_FOR_WAKE;
          else                 state_d = ST_SEND_WAKE;
        end
        ST_WAIT_FOR_WAKE: begin
          if (comm_wake_detect) state_d = ST_WAIT_FOR_NO_WAKE;
          else if (timer_tc_s)  state_d = ST_SEND_RESET;
          else                  state_d = ST_WAIT_FOR_WAKE;
        end
        ST_WAIT_FOR_NO_WAKE: begin
          if (!comm_wake_detect) state_d = ST_WAIT_FOR_IDLE;
          else                   state_d = ST_WAIT_FOR_NO_WAKE;
        end
        ST_WAIT_FOR_IDLE: begin
          if (!rx_is_elec_idle) state_d = ST_WAIT_FOR_ALIGN;
          else                  state_d = ST_WAIT_FOR_IDLE;
        end
        ST_WAIT_FOR_ALIGN: begin
          if (rx_byte_is_aligned && rx_align_s) state_d = ST_SEND_ALIGN;
          else if (timer_tc_s)                  state_d = ST_SEND_RESET;
          else                                  state_d = ST_WAIT_FOR_ALIGN;
        end
        ST_SEND_ALIGN: begin
          // The primitive arriving now is the one that brings the count to its target
          if (rx_non_align_s && (nonalign_q == CNT_LAST)) state_d = ST_READY;
          else                                            state_d = ST_SEND_ALIGN;
        end
        ST_READY: begin
          if (comm_init_detect) state_d = ST_IDLE;
          else                  state_d = ST_READY;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track state_q
  always_comb begin
    linkup_d        = 1'b0;
    tx_dout_d       = 32'h0000_0000;
    tx_isk_d        = 1'b0;
    tx_comm_reset_d = 1'b0;
    tx_comm_wake_d  = 1'b0;
    tx_elec_idle_d  = 1'b1;
    case (state_d)
      ST_SEND_RESET: tx_comm_reset_d = 1'b1;
      ST_SEND_WAKE:  tx_comm_wake_d  = 1'b1;
      ST_WAIT_FOR_IDLE, ST_WAIT_FOR_ALIGN: begin
        tx_elec_idle_d = 1'b0;
        tx_dout_d      = DIALTONE_PRIM;
      end
      ST_SEND_ALIGN: begin
        tx_elec_idle_d = 1'b0;
        tx_dout_d      = ALIGN_PRIM;
        tx_isk_d       = 1'b1;
      end
      ST_READY: begin
        tx_elec_idle_d = 1'b0;
        tx_dout_d      = ALIGN_PRIM;
        tx_isk_d       = 1'b1;
        linkup_d       = 1'b1;
      end
      default: begin
        tx_elec_idle_d = 1'b1;
      end
    endcase
  end

  assign lax_state        = state_q;
  assign linkup           = linkup_q;
  assign tx_dout          = tx_dout_q;
  assign tx_isk           = tx_isk_q;
  assign tx_comm_reset    = tx_comm_reset_q;
  assign tx_comm_wake     = tx_comm_wake_q;
  assign tx_set_elec_idle = tx_elec_idle_q;

endmodule

// File: tb/tb_sata_oob_controller.sv
// Self-checking bench for sata_oob_controller: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model that
// follows the link-bring-up rules directly.
module tb_sata_oob_controller;
  import sata_oob_controller_pkg::*;

  localparam int OOB_TO   = 64;
  localparam int ALIGN_TO = 64;
  localparam int NA_CNT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        platform_ready = 1'b0;
  logic        linkup;
  logic [31:0] tx_dout;
  logic        tx_isk;
  logic        tx_comm_reset;
  logic        tx_comm_wake;
  logic        tx_set_elec_idle;
  logic        tx_oob_complete = 1'b0;
  logic [31:0] rx_din = 32'h0;
  logic [3:0]  rx_isk = 4'h0;
  logic        comm_init_detect = 1'b0;
  logic        comm_wake_detect = 1'b0;
  logic        rx_byte_is_aligned = 1'b0;
  logic        rx_is_elec_idle = 1'b1;
  logic [3:0]  lax_state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, cycles spent in phase, non-ALIGN run length
  int m_code  = 0;
  int m_timer = 0;
  int m_cnt   = 0;

  sata_oob_controller #(
    .OOB_TIMEOUT(OOB_TO), .ALIGN_TIMEOUT(ALIGN_TO), .NON_ALIGN_COUNT(NA_CNT)
  ) dut (
    .clk(clk), .rst(rst), .platform_ready(platform_ready), .linkup(linkup),
    .tx_dout(tx_dout), .tx_isk(tx_isk), .tx_comm_reset(tx_comm_reset),
    .tx_comm_wake(tx_comm_wake), .tx_set_elec_idle(tx_set_elec_idle),
    .tx_oob_complete(tx_oob_complete), .rx_din(rx_din), .rx_isk(rx_isk),
    .comm_init_detect(comm_init_detect), .comm_wake_detect(comm_wake_detect),
    .rx_byte_is_aligned(rx_byte_is_aligned), .rx_is_elec_idle(rx_is_elec_idle),
    .lax_state(lax_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_advance();
    int nxt;
    bit got_align;
    bit got_other_k;
    if (rst) begin
      m_code = 0; m_timer = 0; m_cnt = 0;
      return;
    end
    nxt = m_code;
    got_align   = rx_isk[0] && (rx_din == ALIGN_PRIM);
    got_other_k = rx_isk[0] && (rx_din != ALIGN_PRIM);
    if (m_code == 0 && platform_ready) nxt = 1;
    if (m_code == 1 && tx_oob_complete) nxt = 2;
    if (m_code == 2) nxt = comm_init_detect ? 3 : (m_timer == OOB_TO - 1 ? 1 : 2);
    if (m_code == 3 && !comm_init_detect) nxt = 4;
    if (m_code == 4 && tx_oob_complete) nxt = 5;
    if (m_code == 5) nxt = comm_wake_detect ? 6 : (m_timer == OOB_TO - 1 ? 1 : 5);
    if (m_code == 6 && !comm_wake_detect) nxt = 7;
    if (m_code == 7 && !rx_is_elec_idle) nxt = 8;
    if (m_code == 8) nxt = (rx_byte_is_aligned && got_align) ? 9 : (m_timer == ALIGN_TO - 1 ? 1 : 8);
    if (m_code == 9) begin
      if (got_align) m_cnt = 0;
      else if (got_other_k) m_cnt++;
      if (m_cnt == NA_CNT) nxt = 10;
    end
    if (m_code == 10 && comm_init_detect) nxt = 0;
    if (!platform_ready) nxt = 0;
    if (nxt == 9 && m_code != 9) m_cnt = 0;
    m_timer = (nxt != m_code) ? 0 : m_timer + 1;
    m_code  = nxt;
  endtask

  // Compare every output with what the model's current phase demands
  task automatic check_outputs();
    logic [31:0] e_dout;
    e_dout = (m_code == 7 || m_code == 8) ? DIALTONE_PRIM :
             (m_code >= 9) ? ALIGN_PRIM : 32'h0;
    check("lax_state", 32'(lax_state), 32'(m_code));
    check("linkup", 32'(linkup), 32'(m_code == 10));
    check("tx_dout", tx_dout, e_dout);
    check("tx_isk", 32'(tx_isk), 32'(m_code >= 9));
    check("tx_comm_reset", 32'(tx_comm_reset), 32'(m_code == 1));
    check("tx_comm_wake", 32'(tx_comm_wake), 32'(m_code == 4));
    check("tx_set_elec_idle", 32'(tx_set_elec_idle), 32'(m_code <= 6));
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic rx_word(input logic [31:0] d, input logic k);
    rx_din = d;
    rx_isk = {3'b000, k};
  endtask

  // From SEND_RESET, run a clean handshake up to WAIT_FOR_ALIGN
  task automatic go_to_align();
    rx_is_elec_idle = 1'b1;
    tx_oob_complete = 1'b1; step();
    tx_oob_complete = 1'b0; comm_init_detect = 1'b1; step();
    comm_init_detect = 1'b0; step();
    tx_oob_complete = 1'b1; step();
    tx_oob_complete = 1'b0; comm_wake_detect = 1'b1; step();
    comm_wake_detect = 1'b0; step();
    rx_is_elec_idle = 1'b0; step();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; platform_ready = 1'b0;
    step(); step();
    check("reset_state", 32'(lax_state), 32'd0);
    check("reset_elec_idle", 32'(tx_set_elec_idle), 32'd1);
    rst = 1'b0;
    step();

    // Raise platform_ready: COMRESET request next cycle
    platform_ready = 1'b1; step();
    check("comreset_req", {28'h0, lax_state, tx_comm_reset}, 32'h0000_0003);

    // Happy path with 5-cycle COMINIT and COMWAKE
    tx_oob_complete = 1'b1; step();
    tx_oob_complete = 1'b0; comm_init_detect = 1'b1;
    for (int i = 0; i < 5; i++) step();
    comm_init_detect = 1'b0; step();
    tx_oob_complete = 1'b1; step();
    tx_oob_complete = 1'b0; comm_wake_detect = 1'b1;
    for (int i = 0; i < 5; i++) step();
    comm_wake_detect = 1'b0; step();
    rx_is_elec_idle = 1'b0; step();
    check("dialtone", tx_dout, 32'h4A4A_4A4A);
    check("align_wait_state", 32'(lax_state), 32'd8);
    rx_byte_is_aligned = 1'b1; rx_word(ALIGN_PRIM, 1'b1); step();
    check("send_align", {tx_dout[30:0], tx_isk}, {31'h7B4A_4ABC, 1'b1} & 32'hFFFF_FFFF);
    rx_word(SYNC_PRIM, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check("linkup_after_sync", {28'h0, lax_state}, 32'd10);
    check("linkup_flag", 32'(linkup), 32'd1);

    // Drop platform_ready while link up
    platform_ready = 1'b0; rx_word(32'h0, 1'b0); step();
    check("drop_ready", {30'h0, linkup, tx_set_elec_idle}, 32'h1);

    // No COMINIT: retry COMRESET after the timeout window
    platform_ready = 1'b1; rx_is_elec_idle = 1'b1; step();
    tx_oob_complete = 1'b1; step();
    tx_oob_complete = 1'b0;
    for (int i = 0; i < OOB_TO - 1; i++) step();
    check("init_wait_before_to", 32'(lax_state), 32'd2);
    step();
    check("init_timeout", {28'h0, lax_state, tx_comm_reset}, 32'h0000_0003);

    // Non-ALIGN run broken by an ALIGN
    go_to_align();
    rx_byte_is_aligned = 1'b1; rx_word(ALIGN_PRIM, 1'b1); step();
    rx_word(SYNC_PRIM, 1'b1); step(); step();
    rx_word(ALIGN_PRIM, 1'b1); step();
    rx_word(SYNC_PRIM, 1'b1); step(); step();
    check("broken_run_no_link", 32'(linkup), 32'd0);
    rx_word(32'h1234_5678, 1'b0); step();
    check("data_keeps_count", 32'(linkup), 32'd0);
    rx_word(SYNC_PRIM, 1'b1); step();
    check("third_sync_link", 32'(linkup), 32'd1);

    // Device-initiated COMINIT while ready
    comm_init_detect = 1'b1; step();
    check("cominit_in_ready", 32'(lax_state), 32'd0);
    comm_init_detect = 1'b0; step();

    // ALIGN without byte alignment: times out to COMRESET
    go_to_align();
    rx_byte_is_aligned = 1'b0; rx_word(ALIGN_PRIM, 1'b1);
    for (int i = 0; i < ALIGN_TO - 1; i++) step();
    check("misaligned_hold", 32'(lax_state), 32'd8);
    step();
    check("align_timeout", 32'(lax_state), 32'd1);

    // Randomized traffic, including occasional resets
    for (int n = 0; n < 4000; n++) begin
      int sel;
      rst                = ($urandom_range(0, 199) == 0);
      platform_ready     = ($urandom_range(0, 99) != 0);
      tx_oob_complete    = ($urandom_range(0, 3) == 0);
      comm_init_detect   = ($urandom_range(0, 9) == 0);
      comm_wake_detect   = ($urandom_range(0, 3) == 0);
      rx_byte_is_aligned = ($urandom_range(0, 3) != 0);
      rx_is_elec_idle    = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: rx_word(ALIGN_PRIM, 1'b1);
        1: rx_word(SYNC_PRIM, 1'b1);
        2: rx_word($urandom, 1'b0);
        default: begin
          rx_din = $urandom;
          rx_isk = 4'($urandom_range(0, 15));
        end
      endcase
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
